// File: rtl/led_chaser_pkg.sv
// Shared definitions for the LED chaser: register addresses, CTRL/STATUS
// bit positions and the run/stop state encoding.
package led_chaser_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PERIOD = 2'd1;
  localparam logic [1:0] ADDR_POS    = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int CTRL_RUN    = 0;
  localparam int CTRL_DIR    = 1;
  localparam int CTRL_BOUNCE = 2;
  localparam int CTRL_IRQ_EN = 3;

  localparam int STAT_WRAP = 0;
  localparam int STAT_BTN  = 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/led_chaser_ctrl_btn_edge_sync.sv
// Push-button synchroniser with a single-cycle falling-edge pulse.
// Flops reset to "released" so a reset never manufactures an edge.
module btn_edge_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_n,
  output logic fall
);

  logic d1;
  logic d2;
  logic primed;
  logic armed;

  // armed only after a genuinely sampled high level, so a button already
  // held down when reset is released does not count as a press
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d1     <= 1'b1;
      d2     <= 1'b1;
      primed <= 1'b0;
      armed  <= 1'b0;
    end else begin
      d1     <= btn_n;
      d2     <= d1;
      primed <= 1'b1;
      armed  <= armed | (primed & d1);
    end
  end

  assign fall = armed & ~d1 & d2;

endmodule

// File: rtl/led_chaser_ctrl.sv
// LED chaser sequencer with an Avalon-MM slave: one-hot pattern stepped at a
// programmable rate, wrap or bounce, button toggles run/stop, level irq.
module led_chaser_ctrl
  import led_chaser_pkg::*;
#(
  parameter int          NUM_LEDS       = 8,
  parameter logic [31:0] DEFAULT_PERIOD = 32'd50000000,
  parameter int          POS_W          = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [1:0]          address,
  input  logic                chipselect,
  input  logic                write_n,
  input  logic [31:0]         writedata,
  output logic [31:0]         readdata,
  input  logic                btn_n,
  output logic [NUM_LEDS-1:0] leds,
  output logic                irq
);

  localparam logic [POS_W-1:0] LAST = POS_W'(NUM_LEDS - 1);

  logic [3:0]       ctrl;
  logic [31:0]      period;
  logic [31:0]      presc;
  logic [POS_W-1:0] pos;
  logic [1:0]       status;
  state_t           state;

  logic             btn_fall;
  logic             wr;
  logic             wr_ctrl;
  logic             wr_period;
  logic             wr_pos;
  logic             wr_status;
  logic             pos_ok;
  logic             run_next;
  logic             step;
  logic [POS_W-1:0] step_pos;
  logic             step_dir;
  logic             step_wrap;
  logic [1:0]       w1c;
  logic [1:0]       set_bits;
  logic [31:0]      rd_mux;

  btn_edge_sync u_btn (
    .clk     (clk),
    .reset_n (reset_n),
    .btn_n   (btn_n),
    .fall    (btn_fall)
  );

  assign wr        = chipselect & ~write_n;
  assign wr_ctrl   = wr && (address == ADDR_CTRL);
  assign wr_period = wr && (address == ADDR_PERIOD);
  assign wr_pos    = wr && (address == ADDR_POS);
  assign wr_status = wr && (address == ADDR_STATUS);
  assign pos_ok    = writedata < 32'(NUM_LEDS);

  // A CPU write of CTRL overrides a button toggle in the same cycle.
  always_comb begin
    run_next = ctrl[CTRL_RUN] ^ btn_fall;
    if (wr_ctrl) begin
      run_next = writedata[CTRL_RUN];
    end
  end

  // A step due on the edge that stops the chaser is dropped.
  assign step = (state == RUN) && run_next && (presc == period);

  always_comb begin
    step_pos  = pos;
    step_dir  = ctrl[CTRL_DIR];
    step_wrap = 1'b0;
    if (NUM_LEDS == 1) begin
      step_wrap = 1'b1;
    end else if (!ctrl[CTRL_DIR]) begin
      if (pos == LAST) begin
        step_wrap = 1'b1;
        if (ctrl[CTRL_BOUNCE]) begin
          step_dir = 1'b1;
          step_pos = LAST - POS_W'(1);
        end else begin
          step_pos = '0;
        end
      end else begin
        step_pos = pos + POS_W'(1);
      end
    end else begin
      if (pos == '0) begin
        step_wrap = 1'b1;
        if (ctrl[CTRL_BOUNCE]) begin
          step_dir = 1'b0;
          step_pos = POS_W'(1);
        end else begin
          step_pos = LAST;
        end
      end else begin
        step_pos = pos - POS_W'(1);
      end
    end
  end

  assign w1c      = wr_status ? writedata[1:0] : 2'b00;
  assign set_bits = {btn_fall, step & step_wrap};

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_CTRL:   rd_mux = {28'd0, ctrl};
      ADDR_PERIOD: rd_mux = period;
      ADDR_POS:    rd_mux = 32'(pos);
      ADDR_STATUS: rd_mux = {30'd0, status};
      default:     rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl     <= '0;
      period   <= DEFAULT_PERIOD;
      presc    <= '0;
      pos      <= '0;
      status   <= '0;
      state    <= IDLE;
      readdata <= '0;
    end else begin
      readdata <= rd_mux;
      state    <= run_next ? RUN : IDLE;

      if (wr_period || wr_pos || (state == IDLE) || (presc == period)) begin
        presc <= '0;
      end else begin
        presc <= presc + 32'd1;
      end

      // later assignments win: CPU write over bounce direction flip
      ctrl[CTRL_RUN] <= run_next;
      if (step) begin
        ctrl[CTRL_DIR] <= step_dir;
      end
      if (wr_ctrl) begin
        ctrl[3:1] <= writedata[3:1];
      end

      if (wr_period) begin
        period <= writedata;
      end

      if (wr_pos && pos_ok) begin
        pos <= writedata[POS_W-1:0];
      end else if (step) begin
        pos <= step_pos;
      end

      status <= (status & ~w1c) | set_bits;
    end
  end

  always_comb begin
    leds      = '0;
    leds[pos] = 1'b1;
  end

  assign irq = ctrl[CTRL_IRQ_EN] & (|status);

endmodule
